cdb_arbiter: RTL and testbench

Round-robin arbiter and driver for the Tomasulo common data bus (CDB). Each execution unit (adder bank, multiplier bank, load unit) raises a ready-to-send request with its result and reservation-station tag. The arbiter grants one unit per cycle, pulses that unit's transmit acknowledge, and drives the registered CDB data, source and write strobe consumed by the register file and all reservation stations.

---
 rtl/tomasulo_pkg.sv | 6 +
 rtl/cdb_arbiter_if.sv | 24 ++
 rtl/rr_picker.sv | 29 ++
 rtl/cdb_arbiter.sv | 79 +++++++
 tb/tb_cdb_arbiter.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: default widths and reserved tag values shared by the Tomasulo datapath blocks.
package tomasulo_pkg;
  localparam int DATA_W_DFLT = 32;
  localparam int TAG_W_DFLT = 6;
  localparam logic [TAG_W_DFLT-1:0] NO_TAG = '0;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: execution-unit request bus and common data bus broadcast signals.
interface cdb_arbiter_if
  import tomasulo_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int TAG_W = TAG_W_DFLT
);
  logic [NUM_UNITS-1:0] unit_rts;
  logic [NUM_UNITS*DATA_W-1:0] unit_data;
  logic [NUM_UNITS*TAG_W-1:0] unit_source;
  logic [NUM_UNITS-1:0] unit_xmit;
  logic [DATA_W-1:0] CDB_data;
  logic [TAG_W-1:0] CDB_source;
  logic CDB_write;
  modport master (
    output unit_rts, unit_data, unit_source,
    input unit_xmit, CDB_data, CDB_source, CDB_write
  );
  modport slave (
    input unit_rts, unit_data, unit_source,
    output unit_xmit, CDB_data, CDB_source, CDB_write
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick (rotate by ptr, find lowest set bit, rotate back).
module rr_picker #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] index_o,
  output logic          any_valid_o
);
  logic [2*N-1:0] rot_dbl;
  logic [2*N-1:0] back_dbl;
  logic [N-1:0] rot;
  logic [N-1:0] first;
  assign rot_dbl = {eligible_i, eligible_i} >> ptr_i;
  assign rot = rot_dbl[N-1:0];
  assign back_dbl = {{N{1'b0}}, first} << ptr_i;
  assign grant_o = back_dbl[N-1:0] | back_dbl[2*N-1:N];
  assign any_valid_o = |eligible_i;
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) first = rot[i] ? N'(1) << i : first;
  end
  always_comb begin
    index_o = '0;
    for (int i = 0; i < N; i++) index_o = grant_o[i] ? PW'(i) : index_o;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with registered broadcast outputs.
// Define CDB_ARBITER_STATS_EN to build the saturating broadcast/conflict counters.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int TAG_W = TAG_W_DFLT
) (
  input  logic        clock,
  input  logic        reset,
  cdb_arbiter_if.slave bus,
  output logic [31:0] broadcast_count,
  output logic [31:0] conflict_count
);
  localparam int PW = $clog2(NUM_UNITS);
  logic [NUM_UNITS-1:0] xmit_q, xmit_d, eligible, grant;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0] src_q, src_d;
  logic write_q, write_d;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic any;
  // A unit granted this cycle still shows rts, so it is masked for one arbitration.
  assign eligible = bus.unit_rts & ~xmit_q;
  rr_picker #(.N(NUM_UNITS), .PW(PW)) u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .index_o    (idx),
    .any_valid_o(any)
  );
  always_comb begin
    xmit_d = any ? grant : '0;
    write_d = any;
    data_d = any ? bus.unit_data[int'(idx)*DATA_W +: DATA_W] : data_q;
    src_d = any ? bus.unit_source[int'(idx)*TAG_W +: TAG_W] : src_q;
    ptr_d = !any ? ptr_q : (idx == PW'(NUM_UNITS - 1)) ? '0 : idx + PW'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      xmit_q <= '0;
      data_q <= '0;
      src_q <= '0;
      write_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      xmit_q <= xmit_d;
      data_q <= data_d;
      src_q <= src_d;
      write_q <= write_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.unit_xmit = xmit_q;
  assign bus.CDB_data = data_q;
  assign bus.CDB_source = src_q;
  assign bus.CDB_write = write_q;
`ifdef CDB_ARBITER_STATS_EN
  logic [31:0] bcnt_q, bcnt_d, ccnt_q, ccnt_d;
  always_comb begin
    bcnt_d = (any && bcnt_q != '1) ? bcnt_q + 32'd1 : bcnt_q;
    ccnt_d = ($countones(eligible) > 1 && ccnt_q != '1) ? ccnt_q + 32'd1 : ccnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      ccnt_q <= ccnt_d;
    end
  end
  assign broadcast_count = bcnt_q;
  assign conflict_count = ccnt_q;
`else
  assign broadcast_count = '0;
  assign conflict_count = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of grant order, self-masking, reset override and counters.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int TW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] broadcast_count, conflict_count;
  int n_tests = 0;
  int n_fail = 0;
  cdb_arbiter_if #(.NUM_UNITS(N), .DATA_W(DW), .TAG_W(TW)) bus ();
  cdb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock          (clk),
    .reset          (rst),
    .bus            (bus),
    .broadcast_count(broadcast_count),
    .conflict_count (conflict_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] one_pat [6];
    int w [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    w = '{0, 1, 2, 3, 0};
    one_pat = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    bus.unit_rts = '0;
    bus.unit_data = '0;
    bus.unit_source = '0;
    step();
    do_reset();
    check("rst_xmit", bus.unit_xmit, 0);
    check("rst_write", bus.CDB_write, 0);
    check("rst_data", bus.CDB_data, 0);
    check("rst_src", bus.CDB_source, 0);
    check("rst_ptr", dut.ptr_q, 0);
    check("rst_bcnt", broadcast_count, 0);
    check("rst_ccnt", conflict_count, 0);
    // single request from unit 2
    bus.unit_rts = 4'b0100;
    bus.unit_data[2*DW +: DW] = 32'(-5);
    bus.unit_source[2*TW +: TW] = 6'd9;
    step();
    check("u2_xmit", bus.unit_xmit, 4'b0100);
    check("u2_write", bus.CDB_write, 1);
    check("u2_data", bus.CDB_data, 32'hFFFF_FFFB);
    check("u2_src", bus.CDB_source, 9);
    bus.unit_rts = '0;
    step();
    check("u2_idle_write", bus.CDB_write, 0);
    check("u2_idle_xmit", bus.unit_xmit, 0);
    check("u2_hold_data", bus.CDB_data, 32'hFFFF_FFFB);
    // all four units continuously
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.unit_data[i*DW +: DW] = 32'(100 + i);
      bus.unit_source[i*TW +: TW] = TW'(i + 1);
    end
    bus.unit_rts = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_xmit%0d", k), bus.unit_xmit, exp_seq[k]);
      check($sformatf("rr_write%0d", k), bus.CDB_write, 1);
      check($sformatf("rr_data%0d", k), bus.CDB_data, 64'(100 + w[k]));
      check($sformatf("rr_src%0d", k), bus.CDB_source, 64'(w[k] + 1));
    end
    bus.unit_rts = '0;
    step();
    // lone persistent requester is granted every other cycle
    do_reset();
    bus.unit_rts = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("solo_xmit%0d", k), bus.unit_xmit, one_pat[k]);
    end
    bus.unit_rts = '0;
    step();
    // units 0 and 3 after unit 3 was last winner
    do_reset();
    bus.unit_rts = 4'b1000;
    step();
    check("w3_first", bus.unit_xmit, 4'b1000);
    check("w3_ptr", dut.ptr_q, 0);
    bus.unit_rts = '0;
    step();
    bus.unit_rts = 4'b1001;
    step();
    check("c03_first", bus.unit_xmit, 4'b0001);
    step();
    check("c03_second", bus.unit_xmit, 4'b1000);
    bus.unit_rts = '0;
    step();
`ifdef CDB_ARBITER_STATS_EN
    check("ccnt", conflict_count, 1);
    check("bcnt", broadcast_count, 3);
`else
    check("ccnt", conflict_count, 0);
    check("bcnt", broadcast_count, 0);
`endif
    // reset lands while unit 1 is being granted
    do_reset();
    bus.unit_rts = 4'b0010;
    step();
    check("mid_xmit", bus.unit_xmit, 4'b0010);
    rst = 1'b1;
    step();
    check("mid_rst_xmit", bus.unit_xmit, 0);
    check("mid_rst_write", bus.CDB_write, 0);
    check("mid_rst_data", bus.CDB_data, 0);
    check("mid_rst_src", bus.CDB_source, 0);
    check("mid_rst_ptr", dut.ptr_q, 0);
    rst = 1'b0;
    step();
    check("mid_regrant", bus.unit_xmit, 4'b0010);
    check("mid_regrant_wr", bus.CDB_write, 1);
    bus.unit_rts = '0;
    step();
`ifdef CDB_ARBITER_STATS_EN
    force dut.bcnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bcnt_q;
    bus.unit_rts = 4'b1100;
    step();
    check("sat_one", broadcast_count, 32'hFFFF_FFFF);
    step();
    bus.unit_rts = '0;
    step();
    check("sat_hold", broadcast_count, 32'hFFFF_FFFF);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
